// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_stall_ctrl_if : hazard-detect inputs and pipeline controls    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs_ID;
  logic [4:0]       rt_ID;
  logic             UsesRs_ID;
  logic             UsesRt_ID;
  logic             MemRead_IDEX;
  logic [4:0]       rt_IDEX;
  logic             MulStart_EX;
  logic             BranchTaken_EX;
  logic             PCWrite;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Write;
  logic             IDEX_Bubble;
  logic             EXMEM_Bubble;
  logic             Busy;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output rs_ID, rt_ID, UsesRs_ID, UsesRt_ID, MemRead_IDEX, rt_IDEX,
           MulStart_EX, BranchTaken_EX,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble,
           EXMEM_Bubble, Busy, StallCycles, FlushCount
  );

  modport slave (
    input  rs_ID, rt_ID, UsesRs_ID, UsesRt_ID, MemRead_IDEX, rt_IDEX,
           MulStart_EX, BranchTaken_EX,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble,
           EXMEM_Bubble, Busy, StallCycles, FlushCount
  );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_stall_ctrl : load-use / branch / multiply pipeline sequencer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hazard_stall_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  wire logic          Clk,
  input  wire logic          Reset,
  hazard_stall_ctrl_if.slave bus
);
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  localparam bit         C_MUL_STALL = (MUL_LATENCY > 1);
  localparam bit         C_MUL_MULTI = (MUL_LATENCY >= 3);
  localparam logic [3:0] C_MCNT_INIT = C_MUL_MULTI ? 4'(MUL_LATENCY - 2) : 4'd0;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_mcnt;
  logic [3:0] w_mcnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_load_use;
  logic w_flush;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_write;
  logic w_idex_bubble;
  logic w_exmem_bubble;
  logic w_busy;

  // $0 is hard-wired, so a load targeting it never creates a dependency
  assign w_load_use = bus.MemRead_IDEX && (bus.rt_IDEX != 5'd0) &&
                      ((bus.UsesRs_ID && (bus.rs_ID == bus.rt_IDEX)) ||
                       (bus.UsesRt_ID && (bus.rt_ID == bus.rt_IDEX)));

  always_comb begin
    w_state_nxt    = r_state;
    w_mcnt_nxt     = r_mcnt;
    w_flush        = 1'b0;
    w_pc_write     = 1'b1;
    w_ifid_write   = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_write   = 1'b1;
    w_idex_bubble  = 1'b0;
    w_exmem_bubble = 1'b0;
    w_busy         = 1'b0;
    if (!Reset) begin
      w_state_nxt    = RUN;
      w_mcnt_nxt     = 4'd0;
      w_pc_write     = 1'b0;
      w_ifid_write   = 1'b0;
      w_idex_write   = 1'b0;
      w_ifid_flush   = 1'b1;
      w_idex_bubble  = 1'b1;
      w_exmem_bubble = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.BranchTaken_EX) begin
            w_flush       = 1'b1;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
          end else if (bus.MulStart_EX && C_MUL_STALL) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_idex_write   = 1'b0;
            w_exmem_bubble = 1'b1;
            w_busy         = 1'b1;
            if (C_MUL_MULTI) begin
              w_state_nxt = MUL_BUSY;
              w_mcnt_nxt  = C_MCNT_INIT;
            end
          end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
          end
        end
        MUL_BUSY: begin
          w_pc_write     = 1'b0;
          w_ifid_write   = 1'b0;
          w_idex_write   = 1'b0;
          w_exmem_bubble = 1'b1;
          w_busy         = 1'b1;
          if (r_mcnt == 4'd1) begin
            w_state_nxt = RUN;
          end else begin
            w_mcnt_nxt = r_mcnt - 4'd1;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state     <= RUN;
      r_mcnt      <= 4'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mcnt  <= w_mcnt_nxt;
      if (!w_pc_write && (r_stall_cnt != C_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
      end
      if (w_flush && (r_flush_cnt != C_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
      end
    end
  end

  assign bus.PCWrite      = w_pc_write;
  assign bus.IFID_Write   = w_ifid_write;
  assign bus.IFID_Flush   = w_ifid_flush;
  assign bus.IDEX_Write   = w_idex_write;
  assign bus.IDEX_Bubble  = w_idex_bubble;
  assign bus.EXMEM_Bubble = w_exmem_bubble;
  assign bus.Busy         = w_busy;
  assign bus.StallCycles  = r_stall_cnt;
  assign bus.FlushCount   = r_flush_cnt;
endmodule
`default_nettype wire
